// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO (write clock domain only).
// Keeps the binary and Gray write pointers, drives the memory write port,
// and derives full / almost-full / level from the synchronised read pointer.
module fifo_wr_ctrl #(
  parameter int P_WIDTH    = 4,
  parameter int P_AF_LEVEL = 6
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  input  logic               w_inc,
  input  logic               w_ovf_clr,
  input  logic [P_WIDTH-1:0] wq2_r_ptr,
  output logic [P_WIDTH-1:0] w_gray_ptr,
  output logic [P_WIDTH-2:0] w_addr,
  output logic               w_en,
  output logic               w_full,
  output logic               w_almost_full,
  output logic [P_WIDTH-1:0] w_level,
  output logic               w_overflow
);

  logic [P_WIDTH-1:0] wBin_q, wBin_d;
  logic [P_WIDTH-1:0] wGray_q, wGray_d;
  logic               wOvf_q, wOvf_d;
  logic [P_WIDTH-1:0] rBin;

  // Read pointer back to binary: each bit is the XOR of all Gray bits at and above it
  always_comb begin
    rBin = '0;
    for (int i = 0; i < P_WIDTH; i++) begin
      rBin[i] = ^(wq2_r_ptr >> i);
    end
  end

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal
  assign w_full = (wGray_q == {~wq2_r_ptr[P_WIDTH-1:P_WIDTH-2], wq2_r_ptr[P_WIDTH-3:0]});

  assign w_en          = w_inc & ~w_full;
  assign w_addr        = wBin_q[P_WIDTH-2:0];
  assign w_gray_ptr    = wGray_q;
  assign w_level       = wBin_q - rBin;
  assign w_almost_full = (w_level >= P_WIDTH'(P_AF_LEVEL));
  assign w_overflow    = wOvf_q;

  // Next-state: advance both pointers together on an accepted write; overflow set beats clear
  always_comb begin
    wBin_d  = wBin_q;
    wGray_d = wGray_q;
    wOvf_d  = wOvf_q;
    if (w_en) begin
      wBin_d  = wBin_q + 1'b1;
      wGray_d = wBin_d ^ (wBin_d >> 1);
    end
    if (w_inc & w_full) begin
      wOvf_d = 1'b1;
    end else if (w_ovf_clr) begin
      wOvf_d = 1'b0;
    end
  end

  // State registers, cleared immediately by the asynchronous reset
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wBin_q  <= '0;
      wGray_q <= '0;
      wOvf_q  <= 1'b0;
    end else begin
      wBin_q  <= wBin_d;
      wGray_q <= wGray_d;
      wOvf_q  <= wOvf_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed testbench for fifo_wr_ctrl: reset, fill, overflow, slot freeing,
// wrap-around and mid-operation reset, with hand-computed expectations.
module tb_fifo_wr_ctrl;

  logic       w_clk;
  logic       w_rst_n;
  logic       w_inc;
  logic       w_ovf_clr;
  logic [3:0] wq2_r_ptr;
  logic [3:0] w_gray_ptr;
  logic [2:0] w_addr;
  logic       w_en;
  logic       w_full;
  logic       w_almost_full;
  logic [3:0] w_level;
  logic       w_overflow;

  int checks;
  int failures;

  fifo_wr_ctrl #(.P_WIDTH(4), .P_AF_LEVEL(6)) dut (
    .w_clk         (w_clk),
    .w_rst_n       (w_rst_n),
    .w_inc         (w_inc),
    .w_ovf_clr     (w_ovf_clr),
    .wq2_r_ptr     (wq2_r_ptr),
    .w_gray_ptr    (w_gray_ptr),
    .w_addr        (w_addr),
    .w_en          (w_en),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_level       (w_level),
    .w_overflow    (w_overflow)
  );

  // 10 ns write clock
  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic test_reset();
    w_rst_n = 1'b0;
    w_inc = 1'b0;
    w_ovf_clr = 1'b0;
    wq2_r_ptr = 4'h0;
    step();
    w_inc = 1'b1;
    step();
    checks++; if (w_gray_ptr !== 4'h0) begin failures++; $display("[TB] FAIL reset_gray got=%0h exp=0", w_gray_ptr); end
    checks++; if (w_addr !== 3'd0) begin failures++; $display("[TB] FAIL reset_addr got=%0d exp=0", w_addr); end
    checks++; if (w_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%0b exp=0", w_full); end
    checks++; if (w_level !== 4'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", w_level); end
    checks++; if (w_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%0b exp=0", w_overflow); end
    checks++; if (w_almost_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_af got=%0b exp=0", w_almost_full); end
    checks++; if (w_en !== 1'b1) begin failures++; $display("[TB] FAIL reset_en got=%0b exp=1", w_en); end
    w_inc = 1'b0;
    step();
    w_rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [3:0] grayTab [8];
    grayTab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    wq2_r_ptr = 4'h0;
    for (int i = 0; i < 8; i++) begin
      w_inc = 1'b1;
      #1;
      checks++; if (w_addr !== 3'(i)) begin failures++; $display("[TB] FAIL fill_addr[%0d] got=%0d exp=%0d", i, w_addr, i); end
      checks++; if (w_en !== 1'b1) begin failures++; $display("[TB] FAIL fill_en[%0d] got=%0b exp=1", i, w_en); end
      checks++; if (w_almost_full !== (i >= 6)) begin failures++; $display("[TB] FAIL fill_af[%0d] got=%0b exp=%0b", i, w_almost_full, (i >= 6)); end
      step();
      checks++; if (w_gray_ptr !== grayTab[i]) begin failures++; $display("[TB] FAIL fill_gray[%0d] got=%0h exp=%0h", i, w_gray_ptr, grayTab[i]); end
      checks++; if (w_level !== 4'(i + 1)) begin failures++; $display("[TB] FAIL fill_level[%0d] got=%0d exp=%0d", i, w_level, i + 1); end
    end
    w_inc = 1'b0;
    #1;
    checks++; if (w_full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full got=%0b exp=1", w_full); end
    checks++; if (w_almost_full !== 1'b1) begin failures++; $display("[TB] FAIL fill_af_full got=%0b exp=1", w_almost_full); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      w_inc = 1'b1;
      #1;
      checks++; if (w_en !== 1'b0) begin failures++; $display("[TB] FAIL ovf_en[%0d] got=%0b exp=0", i, w_en); end
      step();
      checks++; if (w_gray_ptr !== 4'hC) begin failures++; $display("[TB] FAIL ovf_gray[%0d] got=%0h exp=c", i, w_gray_ptr); end
      checks++; if (w_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set[%0d] got=%0b exp=1", i, w_overflow); end
    end
    w_inc = 1'b0;
    w_ovf_clr = 1'b1;
    #1;
    checks++; if (w_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_hold_before_clr got=%0b exp=1", w_overflow); end
    step();
    checks++; if (w_overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clr got=%0b exp=0", w_overflow); end
    w_inc = 1'b1;
    step();
    checks++; if (w_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set_wins got=%0b exp=1", w_overflow); end
    w_inc = 1'b0;
    step();
    w_ovf_clr = 1'b0;
    checks++; if (w_overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clr2 got=%0b exp=0", w_overflow); end
  endtask

  task automatic test_free_slot();
    wq2_r_ptr = 4'b0001;
    w_inc = 1'b1;
    #1;
    checks++; if (w_full !== 1'b0) begin failures++; $display("[TB] FAIL free_full got=%0b exp=0", w_full); end
    checks++; if (w_en !== 1'b1) begin failures++; $display("[TB] FAIL free_en got=%0b exp=1", w_en); end
    checks++; if (w_level !== 4'd7) begin failures++; $display("[TB] FAIL free_level got=%0d exp=7", w_level); end
    checks++; if (w_addr !== 3'd0) begin failures++; $display("[TB] FAIL free_addr got=%0d exp=0", w_addr); end
    step();
    w_inc = 1'b0;
    #1;
    checks++; if (w_gray_ptr !== 4'hD) begin failures++; $display("[TB] FAIL free_gray got=%0h exp=d", w_gray_ptr); end
    checks++; if (w_full !== 1'b1) begin failures++; $display("[TB] FAIL free_refull got=%0b exp=1", w_full); end
    checks++; if (w_level !== 4'd8) begin failures++; $display("[TB] FAIL free_level8 got=%0d exp=8", w_level); end
  endtask

  task automatic test_wrap();
    logic [3:0] modelBin;
    logic [3:0] prevGray;
    logic [3:0] expGray;
    w_rst_n = 1'b0;
    wq2_r_ptr = 4'h0;
    #1;
    w_rst_n = 1'b1;
    step();
    modelBin = 4'h0;
    for (int i = 0; i < 16; i++) begin
      prevGray = w_gray_ptr;
      wq2_r_ptr = modelBin ^ (modelBin >> 1);
      w_inc = 1'b1;
      #1;
      checks++; if (w_en !== 1'b1) begin failures++; $display("[TB] FAIL wrap_en[%0d] got=%0b exp=1", i, w_en); end
      step();
      modelBin = modelBin + 4'd1;
      expGray = modelBin ^ (modelBin >> 1);
      checks++; if (w_gray_ptr !== expGray) begin failures++; $display("[TB] FAIL wrap_gray[%0d] got=%0h exp=%0h", i, w_gray_ptr, expGray); end
      checks++; if ($countones(prevGray ^ w_gray_ptr) !== 1) begin failures++; $display("[TB] FAIL wrap_onebit[%0d] got=%0d exp=1", i, $countones(prevGray ^ w_gray_ptr)); end
      checks++; if (w_level !== 4'd1) begin failures++; $display("[TB] FAIL wrap_level[%0d] got=%0d exp=1", i, w_level); end
    end
    w_inc = 1'b0;
    wq2_r_ptr = 4'h0;
    #1;
    checks++; if (w_gray_ptr !== 4'h0) begin failures++; $display("[TB] FAIL wrap_gray_end got=%0h exp=0", w_gray_ptr); end
    checks++; if (w_addr !== 3'd0) begin failures++; $display("[TB] FAIL wrap_addr_end got=%0d exp=0", w_addr); end
    checks++; if (w_level !== 4'd0) begin failures++; $display("[TB] FAIL wrap_level_end got=%0d exp=0", w_level); end
  endtask

  task automatic test_reset_mid();
    wq2_r_ptr = 4'h0;
    w_inc = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (w_addr !== 3'd4) begin failures++; $display("[TB] FAIL mid_addr4 got=%0d exp=4", w_addr); end
    checks++; if (w_gray_ptr !== 4'h6) begin failures++; $display("[TB] FAIL mid_gray4 got=%0h exp=6", w_gray_ptr); end
    #2;
    w_rst_n = 1'b0;
    #1;
    checks++; if (w_gray_ptr !== 4'h0) begin failures++; $display("[TB] FAIL mid_rst_gray got=%0h exp=0", w_gray_ptr); end
    checks++; if (w_addr !== 3'd0) begin failures++; $display("[TB] FAIL mid_rst_addr got=%0d exp=0", w_addr); end
    checks++; if (w_level !== 4'd0) begin failures++; $display("[TB] FAIL mid_rst_level got=%0d exp=0", w_level); end
    checks++; if (w_full !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_full got=%0b exp=0", w_full); end
    checks++; if (w_overflow !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ovf got=%0b exp=0", w_overflow); end
    checks++; if (w_en !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_en got=%0b exp=1", w_en); end
    step();
    w_rst_n = 1'b1;
    #1;
    checks++; if (w_addr !== 3'd0) begin failures++; $display("[TB] FAIL mid_restart_addr got=%0d exp=0", w_addr); end
    step();
    checks++; if (w_addr !== 3'd1) begin failures++; $display("[TB] FAIL mid_restart_addr1 got=%0d exp=1", w_addr); end
    checks++; if (w_gray_ptr !== 4'h1) begin failures++; $display("[TB] FAIL mid_restart_gray got=%0h exp=1", w_gray_ptr); end
    w_inc = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_free_slot();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
